// File: rtl/arp_pkg.sv
// rtl/arp_pkg.sv - shared ARP constants and responder state type
//
// Purpose: EtherType / ARP field constants and the FSM state enum used by
// arp_responder.
// Ports: none (package).

package arp_pkg;

  localparam logic [15:0] ETHERTYPE_ARP    = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
  localparam logic [7:0]  ARP_HLEN_ETH     = 8'd6;
  localparam logic [7:0]  ARP_PLEN_IPV4    = 8'd4;
  localparam logic [15:0] ARP_OPER_REQUEST = 16'd1;
  localparam logic [15:0] ARP_OPER_REPLY   = 16'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_CACHE = 2'd2,
    ST_REPLY = 2'd3
  } arp_state_t;

endpackage

// File: rtl/arp_responder.sv
// rtl/arp_responder.sv - validates parsed ARP frames, issues cache updates and replies
//
// Purpose: accepts one parsed ARP frame at a time, checks its header, writes
// the sender binding to the ARP cache when the frame is addressed to us (or is
// gratuitous), and answers requests for local_ip with a complete reply frame.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   s_frame_* / s_eth_* / s_arp_*   parsed rx frame (valid/ready)
//   m_cache_*               cache write request (valid/ready, ip, mac)
//   m_frame_* / m_eth_* / m_arp_*   reply frame to transmitter (valid/ready)
//   local_mac, local_ip     own addresses, sampled once per frame in CHECK
//   busy                    high whenever not IDLE
//   stat_drop, stat_reply   one-cycle event pulses

module arp_responder
  import arp_pkg::*;
#(
  parameter bit CACHE_GRATUITOUS = 1'b1,
  parameter bit REPLY_ENABLE     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        s_frame_valid,
  output logic        s_frame_ready,
  input  logic [47:0] s_eth_dest_mac,
  input  logic [47:0] s_eth_src_mac,
  input  logic [15:0] s_eth_type,
  input  logic [15:0] s_arp_htype,
  input  logic [15:0] s_arp_ptype,
  input  logic [7:0]  s_arp_hlen,
  input  logic [7:0]  s_arp_plen,
  input  logic [15:0] s_arp_oper,
  input  logic [47:0] s_arp_sha,
  input  logic [31:0] s_arp_spa,
  input  logic [47:0] s_arp_tha,
  input  logic [31:0] s_arp_tpa,

  output logic        m_cache_valid,
  input  logic        m_cache_ready,
  output logic [31:0] m_cache_ip,
  output logic [47:0] m_cache_mac,

  output logic        m_frame_valid,
  input  logic        m_frame_ready,
  output logic [47:0] m_eth_dest_mac,
  output logic [47:0] m_eth_src_mac,
  output logic [15:0] m_eth_type,
  output logic [15:0] m_arp_htype,
  output logic [15:0] m_arp_ptype,
  output logic [7:0]  m_arp_hlen,
  output logic [7:0]  m_arp_plen,
  output logic [15:0] m_arp_oper,
  output logic [47:0] m_arp_sha,
  output logic [31:0] m_arp_spa,
  output logic [47:0] m_arp_tha,
  output logic [31:0] m_arp_tpa,

  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,

  output logic        busy,
  output logic        stat_drop,
  output logic        stat_reply
);

  arp_state_t state_q, state_d;

  // Captured rx frame fields
  logic [15:0] eth_type_q;
  logic [15:0] htype_q;
  logic [15:0] ptype_q;
  logic [7:0]  hlen_q;
  logic [7:0]  plen_q;
  logic [15:0] oper_q;
  logic [47:0] sha_q;
  logic [31:0] spa_q;
  logic [31:0] tpa_q;

  // Local addresses frozen in CHECK so a config change mid-frame cannot tear a reply
  logic [47:0] lmac_q;
  logic [31:0] lip_q;
  logic        reply_q;

  logic hdr_ok, for_us, grat, do_cache, do_reply;

  // The rx destination MAC, source MAC and target hardware address carry no
  // information the responder needs; they exist only for interface symmetry.
  logic unused_rx_fields;
  assign unused_rx_fields = ^{s_eth_dest_mac, s_eth_src_mac, s_arp_tha};

  assign hdr_ok = (eth_type_q == ETHERTYPE_ARP)  &&
                  (htype_q    == ARP_HTYPE_ETH)  &&
                  (ptype_q    == ARP_PTYPE_IPV4) &&
                  (hlen_q     == ARP_HLEN_ETH)   &&
                  (plen_q     == ARP_PLEN_IPV4)  &&
                  ((oper_q == ARP_OPER_REQUEST) || (oper_q == ARP_OPER_REPLY)) &&
                  (spa_q != 32'd0);

  assign for_us   = (tpa_q == local_ip);
  assign grat     = CACHE_GRATUITOUS && (spa_q == tpa_q);
  assign do_cache = hdr_ok && (for_us || grat);
  assign do_reply = hdr_ok && for_us && (oper_q == ARP_OPER_REQUEST) && REPLY_ENABLE;

  assign busy = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      eth_type_q <= '0;
      htype_q    <= '0;
      ptype_q    <= '0;
      hlen_q     <= '0;
      plen_q     <= '0;
      oper_q     <= '0;
      sha_q      <= '0;
      spa_q      <= '0;
      tpa_q      <= '0;
      lmac_q     <= '0;
      lip_q      <= '0;
      reply_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && s_frame_valid) begin
        eth_type_q <= s_eth_type;
        htype_q    <= s_arp_htype;
        ptype_q    <= s_arp_ptype;
        hlen_q     <= s_arp_hlen;
        plen_q     <= s_arp_plen;
        oper_q     <= s_arp_oper;
        sha_q      <= s_arp_sha;
        spa_q      <= s_arp_spa;
        tpa_q      <= s_arp_tpa;
      end
      if (state_q == ST_CHECK) begin
        lmac_q  <= local_mac;
        lip_q   <= local_ip;
        reply_q <= do_reply;
      end
    end
  end

  // Data outputs are zero outside their valid state, so reset clears them
  // purely through the state register.
  always_comb begin
    state_d        = state_q;
    s_frame_ready  = 1'b0;
    m_cache_valid  = 1'b0;
    m_cache_ip     = '0;
    m_cache_mac    = '0;
    m_frame_valid  = 1'b0;
    m_eth_dest_mac = '0;
    m_eth_src_mac  = '0;
    m_eth_type     = '0;
    m_arp_htype    = '0;
    m_arp_ptype    = '0;
    m_arp_hlen     = '0;
    m_arp_plen     = '0;
    m_arp_oper     = '0;
    m_arp_sha      = '0;
    m_arp_spa      = '0;
    m_arp_tha      = '0;
    m_arp_tpa      = '0;
    stat_drop      = 1'b0;
    stat_reply     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Held low while in reset so no upstream frame appears accepted
        s_frame_ready = rst_n;
        if (s_frame_valid) state_d = ST_CHECK;
      end

      ST_CHECK: begin
        if (do_cache) begin
          state_d = ST_CACHE;
        end else if (do_reply) begin
          state_d = ST_REPLY;
        end else begin
          stat_drop = rst_n;
          state_d   = ST_IDLE;
        end
      end

      ST_CACHE: begin
        m_cache_valid = 1'b1;
        m_cache_ip    = spa_q;
        m_cache_mac   = sha_q;
        if (m_cache_ready) state_d = reply_q ? ST_REPLY : ST_IDLE;
      end

      ST_REPLY: begin
        m_frame_valid  = 1'b1;
        m_eth_dest_mac = sha_q;
        m_eth_src_mac  = lmac_q;
        m_eth_type     = ETHERTYPE_ARP;
        m_arp_htype    = ARP_HTYPE_ETH;
        m_arp_ptype    = ARP_PTYPE_IPV4;
        m_arp_hlen     = ARP_HLEN_ETH;
        m_arp_plen     = ARP_PLEN_IPV4;
        m_arp_oper     = ARP_OPER_REPLY;
        m_arp_sha      = lmac_q;
        m_arp_spa      = lip_q;
        m_arp_tha      = sha_q;
        m_arp_tpa      = spa_q;
        if (m_frame_ready) begin
          stat_reply = rst_n;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/arp_responder.md
Name: arp_responder

Overview:
Sits directly downstream of the ARP frame parser and consumes its parsed-frame output (frame valid/ready plus Ethernet and ARP header fields). It validates each frame and emits an ARP cache update (sender IP/MAC) for the cache. For requests targeting the local IP, it builds a fully populated ARP reply frame for the ARP frame transmitter. Frames are processed one at a time; the cache update is always issued before the reply.

Parameters:
CACHE_GRATUITOUS, 1, 1 = also cache the sender of gratuitous ARP (spa == tpa) not addressed to local_ip
REPLY_ENABLE, 1, 0 = never generate replies; cache updates only

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
s_frame_valid  in  1  parsed ARP frame valid
s_frame_ready  out  1  frame accept
s_eth_dest_mac  in  48  rx Ethernet destination (unused, accepted for interface symmetry)
s_eth_src_mac  in  48  rx Ethernet source
s_eth_type  in  16  rx EtherType
s_arp_htype, s_arp_ptype  in  16 each  hardware / protocol type
s_arp_hlen, s_arp_plen  in  8 each  address lengths
s_arp_oper  in  16  operation
s_arp_sha / s_arp_spa / s_arp_tha / s_arp_tpa  in  48/32/48/32  sender/target addresses
m_cache_valid  out  1  cache write request
m_cache_ready  in  1  cache write accept
m_cache_ip  out  32  IP to cache
m_cache_mac  out  48  MAC to cache
m_frame_valid  out  1  reply frame valid
m_frame_ready  in  1  reply frame accept
m_eth_dest_mac, m_eth_src_mac  out  48 each  reply Ethernet addresses
m_eth_type  out  16  reply EtherType
m_arp_htype, m_arp_ptype  out  16 each
m_arp_hlen, m_arp_plen  out  8 each
m_arp_oper  out  16
m_arp_sha / m_arp_spa / m_arp_tha / m_arp_tpa  out  48/32/48/32
local_mac  in  48  own MAC
local_ip  in  32  own IPv4
busy  out  1  high in any state but IDLE
stat_drop  out  1  one-cycle pulse per discarded frame
stat_reply  out  1  one-cycle pulse per accepted reply

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; s_frame_ready, m_cache_valid, m_frame_valid, busy, stat_drop, stat_reply = 0. All data outputs = 0. Any in-flight frame or pending output is discarded. Reset has priority over every handshake in the same cycle.
- States: IDLE, CHECK, CACHE, REPLY.
- IDLE: s_frame_ready = 1. On s_frame_valid & s_frame_ready, register all s_* fields and go to CHECK. s_frame_ready is 0 in every other state.
- CHECK (exactly 1 cycle): local_mac and local_ip are sampled here.
  - hdr_ok = eth_type==0x0806, htype==1, ptype==0x0800, hlen==6, plen==4, oper in {1,2}, spa!=0.
  - for_us = tpa==local_ip.
  - grat = CACHE_GRATUITOUS & spa==tpa.
  - do_cache = hdr_ok & (for_us | grat).
  - do_reply = hdr_ok & for_us & oper==1 & REPLY_ENABLE.
  - do_cache -> CACHE. Else do_reply -> REPLY (cannot occur, since do_reply implies do_cache). Else pulse stat_drop and go to IDLE.
- CACHE: m_cache_valid = 1, m_cache_ip = spa, m_cache_mac = sha, all stable until m_cache_ready. On handshake: do_reply -> REPLY, else IDLE.
- REPLY: m_frame_valid = 1 with fields stable until m_frame_ready:
  - eth_dest = sha, eth_src = local_mac, eth_type = 0x0806
  - htype = 1, ptype = 0x0800, hlen = 6, plen = 4, oper = 2
  - sha = local_mac, spa = local_ip, tha = rx sha, tpa = rx spa
  - On handshake: pulse stat_reply, go to IDLE.
- Latency, with input accepted at edge N:
  - m_cache_valid rises after edge N+1.
  - m_frame_valid rises the cycle after the cache handshake.
  - Next s_frame_ready: the cycle after the final handshake, or after edge N+1 for a dropped frame.
- Back-pressure: valid is held indefinitely and never deasserts without a handshake; data stays constant while valid.
- Config change mid-frame: values sampled in CHECK are used for the rest of that frame.
- No combinational path from m_*_ready to s_frame_ready.

Decomposition:
- Shared package arp_pkg holds:
  - ETHERTYPE_ARP = 16'h0806, ARP_HTYPE_ETH = 16'h0001, ARP_PTYPE_IPV4 = 16'h0800
  - ARP_OPER_REQUEST = 1, ARP_OPER_REPLY = 2
  - state enum type
- Single module; no sub-module is warranted.

Test Plan:
- local_ip 192.168.1.128, local_mac 02:00:00:00:00:00; request spa 192.168.1.100, sha 5a:51:52:53:54:55, tpa 192.168.1.128 -> cache write (c0a80164, 5a5152535455), then reply with oper 2, tha 5a5152535455, tpa c0a80164, eth_dest 5a5152535455, sha 020000000000; stat_reply pulses once.
- Same request with tpa 192.168.1.1 -> no cache write, no reply, stat_drop pulses; s_frame_ready high 2 cycles after accept.
- Gratuitous reply, spa = tpa = 192.168.1.50: CACHE_GRATUITOUS = 1 -> cache write and no reply; CACHE_GRATUITOUS = 0 -> drop.
- Request with hlen 7, or ptype 0x86dd, or eth_type 0x0800 -> drop, no outputs.
- m_cache_ready held low 20 cycles, then m_frame_ready held low 10 cycles -> outputs stable throughout, s_frame_ready stays 0, exactly one of each handshake.
- rst_n low while in REPLY with m_frame_valid = 1 -> next cycle all valids 0, state IDLE; the next request is processed normally.
